multicycle_ctrl_hs: RTL

Multicycle RISC-V (RV32I + optional M) main control FSM with memory ready/wait handshaking, a multi-cycle mul/div unit interface, a wait-timeout watchdog and an illegal-opcode trap state. It sits in the CPU core between the instruction register opcode field and the multicycle datapath, and drives every mux select and write enable of that datapath. It supersedes the fixed-latency multicycle controller for memories and units that stall.

---
 rtl/multicycle_ctrl_hs_pkg.sv | 60 ++++++
 rtl/multicycle_ctrl_hs_if.sv | 26 ++
 rtl/multicycle_ctrl_hs_ctrl_wait_timer.sv | 34 +++
 rtl/multicycle_ctrl_hs.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_hs_pkg.sv
// Shared constants for the stalling multicycle controller: state codes, opcodes,
// datapath select codes and the packed control-word layout.
package multicycle_ctrl_hs_pkg;

    localparam logic [3:0] STATE_FETCH    = 4'd0;
    localparam logic [3:0] STATE_DECODE   = 4'd1;
    localparam logic [3:0] STATE_MEMADR   = 4'd2;
    localparam logic [3:0] STATE_LW       = 4'd3;
    localparam logic [3:0] STATE_LW2      = 4'd4;
    localparam logic [3:0] STATE_SW       = 4'd5;
    localparam logic [3:0] STATE_R1       = 4'd6;
    localparam logic [3:0] STATE_R2       = 4'd7;
    localparam logic [3:0] STATE_IMM      = 4'd8;
    localparam logic [3:0] STATE_BRANCH   = 4'd9;
    localparam logic [3:0] STATE_JAL      = 4'd10;
    localparam logic [3:0] STATE_JALR1    = 4'd11;
    localparam logic [3:0] STATE_JALR2    = 4'd12;
    localparam logic [3:0] STATE_MD_START = 4'd13;
    localparam logic [3:0] STATE_MD_WAIT  = 4'd14;
    localparam logic [3:0] STATE_TRAP     = 4'd15;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MDR = 2'b01;
    localparam logic [1:0] M2R_PC4 = 2'b10;
    localparam logic [1:0] M2R_MD  = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_BRANCH = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_TRAP   = 2'b11;

    typedef struct packed {
        logic       iord;
        logic       irwrite;
        logic       pcwrite;
        logic       pcwcond;
        logic       memwrite;
        logic       memread;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] aluop;
        logic [1:0] alusrcb;
        logic [1:0] pcsource;
        logic [1:0] memtoreg;
        logic       mdstart;
        logic       illegal;
        logic       timeout;
    } ctrl_out_t;

endpackage

// File: rtl/multicycle_ctrl_hs_if.sv
// Opcode/handshake inputs and datapath control outputs of the multicycle controller.
interface multicycle_ctrl_hs_if;
    logic [6:0] iOp;
    logic       iFunct7_0;
    logic       iMemReady;
    logic       iMulDivDone;
    logic       oIorD, oIRWrite, oPCWrite, oPCWriteCond;
    logic       oMemWrite, oMemRead, oRegWrite, oALUSrcA;
    logic [1:0] oALUOp, oALUSrcB, oPCSource, oMemtoReg;
    logic       oMulDivStart, oIllegal, oTimeout;
    logic [3:0] oState;

    modport master (
        input  iOp, iFunct7_0, iMemReady, iMulDivDone,
        output oIorD, oIRWrite, oPCWrite, oPCWriteCond, oMemWrite, oMemRead,
               oRegWrite, oALUSrcA, oALUOp, oALUSrcB, oPCSource, oMemtoReg,
               oMulDivStart, oIllegal, oTimeout, oState
    );

    modport slave (
        output iOp, iFunct7_0, iMemReady, iMulDivDone,
        input  oIorD, oIRWrite, oPCWrite, oPCWriteCond, oMemWrite, oMemRead,
               oRegWrite, oALUSrcA, oALUOp, oALUSrcB, oPCSource, oMemtoReg,
               oMulDivStart, oIllegal, oTimeout, oState
    );
endinterface

// File: rtl/multicycle_ctrl_hs_ctrl_wait_timer.sv
// Stall watchdog: counts consecutive stalled cycles and flags expiry on the
// TIMEOUT_CYC-th one. TIMEOUT_CYC = 0 disables it.
module ctrl_wait_timer #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_stall,
    output logic o_expire
);
    localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    logic [CW-1:0] r_cnt;

    generate
        if (TIMEOUT_CYC > 0) begin : g_wd
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);
            assign o_expire = i_stall && (r_cnt == LAST);
        end else begin : g_nowd
            assign o_expire = 1'b0;
        end
    endgenerate

    // A stall always holds the state, so any non-stalled cycle (ready, done,
    // leaving the wait or expiry) is exactly when the count must restart.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (i_stall && !o_expire)
            r_cnt <= r_cnt + 1'b1;
        else
            r_cnt <= '0;
    end
endmodule

// File: rtl/multicycle_ctrl_hs.sv
// Multicycle RV32I(+M) main control FSM with memory/mul-div stall handshakes,
// a wait watchdog and an illegal-opcode / timeout trap.
module multicycle_ctrl_hs
    import multicycle_ctrl_hs_pkg::*;
#(
    parameter int MEM_WAIT_EN = 1,
    parameter int MULDIV_EN   = 1,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  iCLK,
    input  logic                  iRST_n,
    multicycle_ctrl_hs_if.master  bus
);
    logic [3:0] r_state, w_next;
    logic       r_md_pending, r_cause_ill, r_cause_to;
    logic       w_ready, w_md_route, w_stall, w_expire, w_trap_ill;
    ctrl_out_t  w_o;

    assign w_ready    = (MEM_WAIT_EN != 0) ? bus.iMemReady : 1'b1;
    assign w_md_route = (MULDIV_EN != 0) && bus.iFunct7_0;

    ctrl_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wait_timer (
        .i_clk    (iCLK),
        .i_rst_n  (iRST_n),
        .i_stall  (w_stall),
        .o_expire (w_expire)
    );

    always_comb begin
        w_next     = r_state;
        w_stall    = 1'b0;
        w_trap_ill = 1'b0;
        case (r_state)
            STATE_FETCH:  if (w_ready) w_next = STATE_DECODE; else w_stall = 1'b1;
            STATE_DECODE: begin
                case (bus.iOp)
                    OPC_LOAD, OPC_STORE:             w_next = STATE_MEMADR;
                    OPC_OP:                          w_next = w_md_route ? STATE_MD_START : STATE_R1;
                    OPC_OP_IMM, OPC_LUI, OPC_AUIPC:  w_next = STATE_IMM;
                    OPC_BRANCH:                      w_next = STATE_BRANCH;
                    OPC_JAL:                         w_next = STATE_JAL;
                    OPC_JALR:                        w_next = STATE_JALR1;
                    default: begin
                        w_next     = STATE_TRAP;
                        w_trap_ill = 1'b1;
                    end
                endcase
            end
            STATE_MEMADR:   w_next = (bus.iOp == OPC_LOAD) ? STATE_LW : STATE_SW;
            STATE_LW:       if (w_ready) w_next = STATE_LW2; else w_stall = 1'b1;
            STATE_SW:       if (w_ready) w_next = STATE_FETCH; else w_stall = 1'b1;
            STATE_R1:       w_next = STATE_R2;
            STATE_IMM:      w_next = STATE_R2;
            STATE_JALR1:    w_next = STATE_JALR2;
            STATE_MD_START: w_next = STATE_MD_WAIT;
            STATE_MD_WAIT:  if (bus.iMulDivDone) w_next = STATE_R2; else w_stall = 1'b1;
            default:        w_next = STATE_FETCH;
        endcase
        if (w_expire)
            w_next = STATE_TRAP;
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_state      <= STATE_FETCH;
            r_md_pending <= 1'b0;
            r_cause_ill  <= 1'b0;
            r_cause_to   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next == STATE_TRAP) begin
                r_cause_ill <= w_trap_ill;
                r_cause_to  <= w_expire;
            end
            // Marks the R2 pass that writes back the mul/div result.
            if (r_state == STATE_MD_WAIT && w_next == STATE_R2)
                r_md_pending <= 1'b1;
            else if (r_state == STATE_R2)
                r_md_pending <= 1'b0;
        end
    end

    always_comb begin
        w_o = '0;
        case (r_state)
            STATE_FETCH: begin
                w_o.memread = 1'b1;
                w_o.alusrcb = 2'b01;
                w_o.irwrite = w_ready;
                w_o.pcwrite = w_ready;
            end
            STATE_DECODE: w_o.alusrcb = 2'b11;
            STATE_MEMADR, STATE_JALR1: begin
                w_o.alusrca = 1'b1;
                w_o.alusrcb = 2'b10;
            end
            STATE_LW: begin
                w_o.memread = 1'b1;
                w_o.iord    = 1'b1;
            end
            STATE_LW2: begin
                w_o.regwrite = 1'b1;
                w_o.memtoreg = M2R_MDR;
            end
            STATE_SW: begin
                w_o.memwrite = 1'b1;
                w_o.iord     = 1'b1;
            end
            STATE_R1: begin
                w_o.alusrca = 1'b1;
                w_o.aluop   = 2'b10;
            end
            STATE_IMM: begin
                w_o.alusrca = 1'b1;
                w_o.alusrcb = 2'b10;
                w_o.aluop   = 2'b11;
            end
            STATE_R2: begin
                w_o.regwrite = 1'b1;
                w_o.memtoreg = r_md_pending ? M2R_MD : M2R_ALU;
            end
            STATE_BRANCH: begin
                w_o.alusrca  = 1'b1;
                w_o.aluop    = 2'b01;
                w_o.pcwcond  = 1'b1;
                w_o.pcsource = PCS_BRANCH;
            end
            STATE_JAL, STATE_JALR2: begin
                w_o.regwrite = 1'b1;
                w_o.memtoreg = M2R_PC4;
                w_o.pcwrite  = 1'b1;
                w_o.pcsource = PCS_JUMP;
            end
            STATE_MD_START: w_o.mdstart = 1'b1;
            STATE_TRAP: begin
                w_o.pcwrite  = 1'b1;
                w_o.pcsource = PCS_TRAP;
                w_o.illegal  = r_cause_ill;
                w_o.timeout  = r_cause_to;
            end
            default: ;
        endcase
        // FETCH strobes depend on live inputs, so gate everything during reset.
        if (!iRST_n)
            w_o = '0;
    end

    assign bus.oIorD        = w_o.iord;
    assign bus.oIRWrite     = w_o.irwrite;
    assign bus.oPCWrite     = w_o.pcwrite;
    assign bus.oPCWriteCond = w_o.pcwcond;
    assign bus.oMemWrite    = w_o.memwrite;
    assign bus.oMemRead     = w_o.memread;
    assign bus.oRegWrite    = w_o.regwrite;
    assign bus.oALUSrcA     = w_o.alusrca;
    assign bus.oALUOp       = w_o.aluop;
    assign bus.oALUSrcB     = w_o.alusrcb;
    assign bus.oPCSource    = w_o.pcsource;
    assign bus.oMemtoReg    = w_o.memtoreg;
    assign bus.oMulDivStart = w_o.mdstart;
    assign bus.oIllegal     = w_o.illegal;
    assign bus.oTimeout     = w_o.timeout;
    assign bus.oState       = r_state;
endmodule
